m_seq_gen: RTL
==============

Name: m_seq_gen

Overview:
Parametrised maximal-length (m-sequence) LFSR generator, the next generation of the team's fixed 20-bit generator. Width, tap mask, reset seed and Fibonacci/Galois mode are parameters. Adds a step enable, runtime seed load, all-zero lock-up recovery with a flag, and a sequence-wrap strobe. It feeds scramblers and PRBS test sources in the datapath.

Parameters:
WIDTH, 20, LFSR length in bits (range 3..32).
TAPS, 20'h00009, feedback mask of WIDTH bits; meaning depends on MODE.
SEED, all ones, state loaded at reset; must be non-zero.
MODE, 0, 0 = Fibonacci (right shift, XOR feedback into MSB); 1 = Galois (right shift, conditional XOR of TAPS).

Ports:
sclk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-high
en  in  1  advance the LFSR one step this cycle
load  in  1  load seed_in this cycle; has priority over en
seed_in  in  WIDTH  runtime seed
m_seq  out  WIDTH  current LFSR state (register output)
m_bit  out  1  serial output, equal to m_seq[0]
wrap  out  1  one-cycle pulse when the state returns to the reference seed
lockup  out  1  one-cycle pulse when an all-zero state is recovered
period  out  WIDTH  measured sequence length (optional feature; 0 when compiled out)

Behaviour:
- Reset (rst_n=1, asynchronous): m_seq=SEED, ref_seed=SEED, wrap=0, lockup=0, step counter=0, period=0.
- Priority per cycle: load > all-zero recovery > en step > hold.
- load=1:
  - m_seq<=seed_in verbatim; zero is allowed.
  - ref_seed<=seed_in only if seed_in != 0; otherwise ref_seed is unchanged.
  - wrap=0 and lockup=0 that cycle; step counter<=0.
- Recovery: en=1, load=0 and m_seq==0:
  - m_seq<=1<<(WIDTH-1); no shift that cycle.
  - lockup=1 for the following cycle.
  - step counter<=0.
- Step in Fibonacci (MODE=0): en=1, load=0, m_seq!=0.
  - fb = XOR of m_seq[i] over all i where TAPS[i]=1.
  - m_seq <= {fb, m_seq[WIDTH-1:1]}.
- Step in Galois (MODE=1): en=1, load=0, m_seq!=0.
  - m_seq <= (m_seq>>1) ^ (m_seq[0] ? TAPS : 0).
- en=0 and load=0: state holds; wrap=0 and lockup=0.
- Latency: one sclk from en to the new m_seq. m_bit is combinational from the register; no extra delay.
- wrap: registered. High for exactly the one cycle in which m_seq has just stepped into a state equal to ref_seed. Never asserted on load, recovery or reset.
- lockup and wrap are never high in the same cycle.
- Reset asserted mid-sequence returns to SEED immediately, regardless of en or load.

Optional Feature:
M_SEQ_PERIOD_EN:
- Defined:
  - A WIDTH-bit step counter increments on every non-recovery step.
  - On a step that asserts wrap: period<=counter+1 and counter<=0.
  - The counter saturates at all ones.
  - period holds its value until the next wrap or reset; load and recovery clear only the counter.
- Undefined: no counter logic; period tied to 0.

Test Plan:
- WIDTH=4, TAPS=4'b0011, MODE=0, SEED=4'hF: release reset, en=1 -> m_seq F,7,3,1,8,... Exactly 15 distinct states, then wrap=1 on the cycle m_seq returns to F; period=15 with M_SEQ_PERIOD_EN.
- Default parameters: after reset m_seq=20'hFFFFF; one en -> 20'h7FFFF. Measured period 2^20-1 (1048575) with M_SEQ_PERIOD_EN.
- WIDTH=4: load=1, seed_in=0, then en=1 -> m_seq=0 for one cycle, then 4'h8 with lockup pulse; ref_seed stays F and wrap fires on the next return to F.
- WIDTH=4, MODE=1, TAPS=4'b1100: from F, en=1 -> B. Full cycle of 15 states, then wrap.
- load=1 and en=1 together with seed_in=4'h5 -> m_seq=5, no step, no wrap. en gaps hold state and the period count is unaffected by idle cycles.
- rst_n pulsed mid-sequence (state 3) -> m_seq=F asynchronously; wrap, lockup and period cleared.

Source files
------------

// File: rtl/m_seq_gen.sv
// Parametrised m-sequence LFSR with step enable, seed load, lock-up recovery and wrap strobe.
// Optional period measurement is compiled in with `define M_SEQ_PERIOD_EN.
module m_seq_gen #(
    parameter int unsigned      WIDTH = 20,
    parameter logic [WIDTH-1:0] TAPS  = 20'h00009,
    parameter logic [WIDTH-1:0] SEED  = '1,
    parameter int unsigned      MODE  = 0
) (
    input  logic             sclk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] m_seq,
    output logic             m_bit,
    output logic             wrap,
    output logic             lockup,
    output logic [WIDTH-1:0] period
);

    logic [WIDTH-1:0] seq_q, seq_d;
    logic [WIDTH-1:0] ref_q, ref_d;
    logic             wrap_q, wrap_d;
    logic             lockup_q, lockup_d;
    logic [WIDTH-1:0] step_val;
    logic             fb;

    always_comb begin
        fb = ^(seq_q & TAPS);
        if (MODE == 0) begin
            step_val = {fb, seq_q[WIDTH-1:1]};
        end else begin
            step_val = (seq_q >> 1) ^ (seq_q[0] ? TAPS : '0);
        end
    end

    always_comb begin
        seq_d    = seq_q;
        ref_d    = ref_q;
        wrap_d   = 1'b0;
        lockup_d = 1'b0;
        if (load) begin
            seq_d = seed_in;
            // A zero seed is loadable but can never be the wrap reference.
            if (seed_in != '0) begin
                ref_d = seed_in;
            end
        end else if (en) begin
            if (seq_q == '0) begin
                seq_d    = {1'b1, {(WIDTH-1){1'b0}}};
                lockup_d = 1'b1;
            end else begin
                seq_d  = step_val;
                wrap_d = (step_val == ref_q);
            end
        end
    end

    always_ff @(posedge sclk or posedge rst_n) begin
        if (rst_n) begin
            seq_q    <= SEED;
            ref_q    <= SEED;
            wrap_q   <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            seq_q    <= seq_d;
            ref_q    <= ref_d;
            wrap_q   <= wrap_d;
            lockup_q <= lockup_d;
        end
    end

`ifdef M_SEQ_PERIOD_EN
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             cnt_clr;
    logic             cnt_inc;

    always_comb begin
        cnt_clr  = load | (en & (seq_q == '0));
        cnt_inc  = ~load & en & (seq_q != '0);
        cnt_d    = cnt_q;
        period_d = period_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (cnt_inc) begin
            if (wrap_d) begin
                period_d = cnt_q + 1'b1;
                cnt_d    = '0;
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge sclk or posedge rst_n) begin
        if (rst_n) begin
            cnt_q    <= '0;
            period_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
        end
    end

    assign period = period_q;
`else
    assign period = '0;
`endif

    assign m_seq  = seq_q;
    assign m_bit  = seq_q[0];
    assign wrap   = wrap_q;
    assign lockup = lockup_q;

endmodule
